// File: rtl/csi2_pkg.sv
// Shared types, data-type codes and header/payload check functions for the CSI-2 packet parser.
package csi2_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned REM_W  = 17;
  localparam int unsigned CRC_W  = 16;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_e;

  // 6-bit Hamming parity over the 24-bit header {WC, DI}
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  // One byte of reflected CRC-16 (poly 0x8408), LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16_4b.sv
// Stateless CRC-16 update over up to four bytes per cycle; enabled bytes must start at lane 0.
module csi2_crc16_4b
  import csi2_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  en_i,
  output logic [15:0] crc_o
);

  logic [CRC_W-1:0] c;

  always_comb begin
    c = crc_i;
    for (int k = 0; k < 4; k++) begin
      if (en_i[k]) c = crc16_byte(c, data_i[BYTE_W*k +: BYTE_W]);
    end
    crc_o = c;
  end

endmodule

// File: rtl/csi2_pkt_parser.sv
// Splits the 4-lane byte stream after HS sync into CSI-2 short/long packets,
// checking header ECC and payload CRC-16.
module csi2_pkt_parser
  import csi2_pkg::*;
#(
  parameter int unsigned NUM_RX_LANE = 4,
  parameter int unsigned RX_GEAR     = 8
) (
  input  logic        clk_byte_i,
  input  logic        reset_byte_i,
  input  logic [7:0]  bd0_i,
  input  logic [7:0]  bd1_i,
  input  logic [7:0]  bd2_i,
  input  logic [7:0]  bd3_i,
  input  logic        hs_sync_i,
  output logic        sp_valid_o,
  output logic [1:0]  sp_vc_o,
  output logic [5:0]  sp_dt_o,
  output logic [15:0] sp_data_o,
  output logic        lp_hdr_valid_o,
  output logic [1:0]  lp_vc_o,
  output logic [5:0]  lp_dt_o,
  output logic [15:0] lp_wc_o,
  output logic        pl_valid_o,
  output logic [31:0] pl_data_o,
  output logic [3:0]  pl_be_o,
  output logic        pl_last_o,
  output logic        pkt_done_o,
  output logic        crc_err_o,
  output logic        ecc_err_o,
  output logic        pkt_abort_o
);

  localparam int unsigned WORD_W = NUM_RX_LANE * RX_GEAR;

  state_e            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [CRC_W-1:0]  crc_q, crc_d, rx_crc_q, rx_crc_d;
  logic              sp_valid_q, sp_valid_d, lp_hdr_valid_q, lp_hdr_valid_d;
  logic [1:0]        sp_vc_q, sp_vc_d, lp_vc_q, lp_vc_d;
  logic [5:0]        sp_dt_q, sp_dt_d, lp_dt_q, lp_dt_d;
  logic [15:0]       sp_data_q, sp_data_d, lp_wc_q, lp_wc_d;
  logic              pl_valid_q, pl_valid_d, pl_last_q, pl_last_d;
  logic [WORD_W-1:0] pl_data_q, pl_data_d;
  logic [3:0]        pl_be_q, pl_be_d;
  logic              pkt_done_q, pkt_done_d, crc_err_q, crc_err_d;
  logic              ecc_err_q, ecc_err_d, pkt_abort_q, pkt_abort_d;

  logic [WORD_W-1:0] word_c;
  logic              ecc_bad_c;
  logic [3:0]        be_c;
  logic [7:0]        rx_lo_c, rx_hi_c;
  logic [CRC_W-1:0]  crc_next_c;

  assign word_c    = {bd3_i, bd2_i, bd1_i, bd0_i};
  assign ecc_bad_c = (word_c[31:30] != 2'b00) || (word_c[29:24] != ecc6(word_c[23:0]));

  // Classify each lane by bytes still owed: >2 payload, 2 CRC LSB, 1 CRC MSB, else padding
  always_comb begin
    be_c    = 4'b0000;
    rx_lo_c = rx_crc_q[7:0];
    rx_hi_c = rx_crc_q[15:8];
    for (int k = 0; k < 4; k++) begin
      be_c[k] = rem_q > REM_W'(k + 2);
      if (rem_q == REM_W'(k + 2)) rx_lo_c = word_c[BYTE_W*k +: BYTE_W];
      if (rem_q == REM_W'(k + 1)) rx_hi_c = word_c[BYTE_W*k +: BYTE_W];
    end
  end

  csi2_crc16_4b u_crc (
    .crc_i  (crc_q),
    .data_i (word_c),
    .en_i   (be_c),
    .crc_o  (crc_next_c)
  );

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    crc_d          = crc_q;
    rx_crc_d       = rx_crc_q;
    sp_valid_d     = 1'b0;
    sp_vc_d        = sp_vc_q;
    sp_dt_d        = sp_dt_q;
    sp_data_d      = sp_data_q;
    lp_hdr_valid_d = 1'b0;
    lp_vc_d        = lp_vc_q;
    lp_dt_d        = lp_dt_q;
    lp_wc_d        = lp_wc_q;
    pl_valid_d     = 1'b0;
    pl_data_d      = pl_data_q;
    pl_be_d        = 4'b0000;
    pl_last_d      = 1'b0;
    pkt_done_d     = 1'b0;
    crc_err_d      = 1'b0;
    ecc_err_d      = 1'b0;
    pkt_abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs_sync_i) state_d = ST_HDR;
      end
      ST_HDR: begin
        state_d = ST_IDLE;
        if (ecc_bad_c) begin
          ecc_err_d = 1'b1;
        end else if (word_c[5:0] <= SHORT_DT_MAX) begin
          sp_valid_d = 1'b1;
          sp_vc_d    = word_c[7:6];
          sp_dt_d    = word_c[5:0];
          sp_data_d  = word_c[23:8];
        end else begin
          lp_hdr_valid_d = 1'b1;
          lp_vc_d        = word_c[7:6];
          lp_dt_d        = word_c[5:0];
          lp_wc_d        = word_c[23:8];
          rem_d          = REM_W'(word_c[23:8]) + REM_W'(2);
          crc_d          = 16'hFFFF;
          rx_crc_d       = 16'h0000;
          state_d        = ST_PAY;
        end
        // A sync on the header cycle restarts header capture next cycle
        if (hs_sync_i) state_d = ST_HDR;
      end
      ST_PAY: begin
        if (hs_sync_i) begin
          pkt_abort_d = 1'b1;
          state_d     = ST_HDR;
        end else begin
          pl_valid_d = |be_c;
          pl_data_d  = word_c;
          pl_be_d    = be_c;
          pl_last_d  = (rem_q >= REM_W'(3)) && (rem_q <= REM_W'(6));
          crc_d      = crc_next_c;
          rx_crc_d   = {rx_hi_c, rx_lo_c};
          if (rem_q <= REM_W'(4)) begin
            rem_d      = '0;
            pkt_done_d = 1'b1;
            crc_err_d  = crc_next_c != {rx_hi_c, rx_lo_c};
            state_d    = ST_IDLE;
          end else begin
            rem_d = rem_q - REM_W'(4);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_byte_i or posedge reset_byte_i) begin
    if (reset_byte_i) begin
      state_q        <= ST_IDLE;
      rem_q          <= '0;
      crc_q          <= '0;
      rx_crc_q       <= '0;
      sp_valid_q     <= 1'b0;
      sp_vc_q        <= '0;
      sp_dt_q        <= '0;
      sp_data_q      <= '0;
      lp_hdr_valid_q <= 1'b0;
      lp_vc_q        <= '0;
      lp_dt_q        <= '0;
      lp_wc_q        <= '0;
      pl_valid_q     <= 1'b0;
      pl_data_q      <= '0;
      pl_be_q        <= '0;
      pl_last_q      <= 1'b0;
      pkt_done_q     <= 1'b0;
      crc_err_q      <= 1'b0;
      ecc_err_q      <= 1'b0;
      pkt_abort_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      crc_q          <= crc_d;
      rx_crc_q       <= rx_crc_d;
      sp_valid_q     <= sp_valid_d;
      sp_vc_q        <= sp_vc_d;
      sp_dt_q        <= sp_dt_d;
      sp_data_q      <= sp_data_d;
      lp_hdr_valid_q <= lp_hdr_valid_d;
      lp_vc_q        <= lp_vc_d;
      lp_dt_q        <= lp_dt_d;
      lp_wc_q        <= lp_wc_d;
      pl_valid_q     <= pl_valid_d;
      pl_data_q      <= pl_data_d;
      pl_be_q        <= pl_be_d;
      pl_last_q      <= pl_last_d;
      pkt_done_q     <= pkt_done_d;
      crc_err_q      <= crc_err_d;
      ecc_err_q      <= ecc_err_d;
      pkt_abort_q    <= pkt_abort_d;
    end
  end

  assign sp_valid_o     = sp_valid_q;
  assign sp_vc_o        = sp_vc_q;
  assign sp_dt_o        = sp_dt_q;
  assign sp_data_o      = sp_data_q;
  assign lp_hdr_valid_o = lp_hdr_valid_q;
  assign lp_vc_o        = lp_vc_q;
  assign lp_dt_o        = lp_dt_q;
  assign lp_wc_o        = lp_wc_q;
  assign pl_valid_o     = pl_valid_q;
  assign pl_data_o      = pl_data_q;
  assign pl_be_o        = pl_be_q;
  assign pl_last_o      = pl_last_q;
  assign pkt_done_o     = pkt_done_q;
  assign crc_err_o      = crc_err_q;
  assign ecc_err_o      = ecc_err_q;
  assign pkt_abort_o    = pkt_abort_q;

endmodule

// File: doc/csi2_pkt_parser.md
# csi2_pkt_parser

Consumes the 4-lane, Gear-8 byte stream leaving the D-PHY receive wrapper, starting at its lane-aligned HS sync indication. Splits the stream into CSI-2 packets:
- checks the 6-bit header ECC (detect only, no correction);
- reports short packets;
- emits long-packet payload as byte-enabled 32-bit words;
- checks the payload CRC-16.

It sits between the D-PHY receive wrapper and the virtual-channel merge logic of the CSI-2 4-to-1 bridge.

## Interface
Parameters:
- `NUM_RX_LANE`, 4: lane count. Only 4 is supported in this revision.
- `RX_GEAR`, 8: bits per lane per clock. Only 8 is supported.

Ports:
- `clk_byte_i`  in  1: byte clock from the D-PHY wrapper; the block's only clock.
- `reset_byte_i`  in  1: asynchronous, active-high reset.
- `bd0_i`..`bd3_i`  in  8 each: lane bytes. Lane 0 carries the lowest-order byte.
- `hs_sync_i`  in  1: single-cycle pulse on the cycle the sync byte B8 is present on all lanes.
- `sp_valid_o`  out  1: short-packet strobe.
- `sp_vc_o`  out  2: short-packet virtual channel.
- `sp_dt_o`  out  6: short-packet data type.
- `sp_data_o`  out  16: short-packet data field.
- `lp_hdr_valid_o`  out  1: long-packet header strobe.
- `lp_vc_o`  out  2: long-packet virtual channel.
- `lp_dt_o`  out  6: long-packet data type.
- `lp_wc_o`  out  16: long-packet word count.
- `pl_valid_o`  out  1: payload word valid.
- `pl_data_o`  out  32: payload word.
- `pl_be_o`  out  4: payload byte enables.
- `pl_last_o`  out  1: last payload word of the packet.
- `pkt_done_o`  out  1: long packet finished (all CRC bytes consumed).
- `crc_err_o`  out  1: CRC mismatch. Valid only together with `pkt_done_o`.
- `ecc_err_o`  out  1: header ECC mismatch; the packet is dropped.
- `pkt_abort_o`  out  1: packet cut short by a new `hs_sync_i`.

## Operation
- There is no back-pressure; the source cannot stall.
- Input word: W = {bd3,bd2,bd1,bd0}.
- State machine, with transitions:
  - IDLE: go to HDR when `hs_sync_i`=1.
  - HDR: decode W as the packet header.
    - Header bytes: DI=bd0, WC={bd2,bd1}, ECC=bd3.
    - VC = DI[7:6], DT = DI[5:0].
    - Compute the 6-bit ECC over {WC,DI}.
    - If ECC[7:6]≠0 or ECC[5:0] mismatches: pulse `ecc_err_o` and go to IDLE.
    - Else if DT<0x10 (short packet): pulse `sp_valid_o` and go to IDLE.
    - Else (long packet): pulse `lp_hdr_valid_o`, load rem = WC+2 (17-bit), set CRC to 0xFFFF and go to PAY.
  - PAY: each cycle, consume the lane bytes in order 0→3.
    - Bytes at stream index < WC are payload: set their `pl_be_o` bit and feed them to the CRC.
    - Bytes at stream index WC and WC+1 are received CRC LSB and MSB.
    - Bytes at index ≥ WC+2 are padding and are ignored.
    - `pl_valid_o`=1 when at least one payload byte is present.
    - `pl_last_o`=1 on the word containing payload byte WC−1.
    - rem decrements by min(rem,4).
    - When rem reaches 0: pulse `pkt_done_o`, set `crc_err_o` = (computed≠received) and go to IDLE.
- Disabled byte lanes of `pl_data_o` carry the raw input byte; consumers ignore them.
- CRC-16 parameters:
  - polynomial x^16+x^12+x^5+1, reflected form (0x8408);
  - initial value 0xFFFF, no final XOR;
  - bytes processed LSB first.
- WC=0: no `pl_valid_o`. The CRC bytes arrive in the first PAY word, and the computed CRC is 0xFFFF.
- `hs_sync_i` in HDR or PAY: if in PAY, pulse `pkt_abort_o`; then go to HDR. No `pkt_done_o` is produced for the cut packet.
- `hs_sync_i` is ignored on the HDR cycle's own data; that cycle's W is still treated as the header.

## Timing
- Every output is registered and resets to 0.
- Reset is asynchronous. Asserting it mid-packet clears the state to IDLE immediately, with no abort pulse.
- Latency:
  - header word at cycle N → `sp_valid_o`, `lp_hdr_valid_o` or `ecc_err_o` at N+1;
  - payload word at M → `pl_*` at M+1;
  - word holding the last CRC byte at K → `pkt_done_o`/`crc_err_o` at K+1.
- `pl_last_o` and `pkt_done_o` coincide when the last payload byte and both CRC bytes share one word. Otherwise `pkt_done_o` comes exactly one cycle later.
- All strobes are single-cycle. Back-to-back packets are accepted: a header may arrive 2 cycles after the previous packet's last word (sync cycle in between).

## Structure
- Package `csi2_pkg` holds:
  - DT constants: FS 0x00, FE 0x01, LS 0x02, LE 0x03, RAW8 0x2A, RAW10 0x2B;
  - SHORT_DT_MAX 0x0F;
  - function `ecc6(input [23:0])`;
  - function `crc16_byte(crc, byte)`.
- Sub-module `csi2_crc16_4b`: a 4-byte-per-cycle CRC update with per-byte enable, built from four chained `crc16_byte` steps. It has no state of its own; the parser holds the CRC register.

## Test plan
- Short packet FS: DI=0x40, WC=0x0001, correct ECC → one `sp_valid_o` with vc=1, dt=0x00, data=0x0001 one cycle after the header; no `pl_valid_o`.
- RAW10 long packet: DI=0x2B, WC=6, payload 01..06, correct CRC.
  - Expected: `lp_wc_o`=6.
  - Word 1: be=0xF, data 0x04030201.
  - Word 2: be=0x3, last=1, `pkt_done_o`=1, `crc_err_o`=0.
- Same packet with payload byte 3 flipped → `pkt_done_o`=1 with `crc_err_o`=1.
- WC=0 long packet with CRC 0xFFFF → no `pl_valid_o`; `pkt_done_o`=1, `crc_err_o`=0 on the first word after the header.
- Header with ECC bit 2 flipped → `ecc_err_o`=1, no `sp`/`lp` strobes, returns to IDLE.
- `hs_sync_i` after 2 payload words of a WC=64 packet → `pkt_abort_o`=1; the next header is decoded normally. Separately: reset asserted mid-PAY → all outputs 0 immediately.
